// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared pipeline definitions for the WB control field
//
// Purpose: widths, bit positions and the typedef of the 2-bit WB control
// field produced by the ID opcode decoder and consumed by MEM/WB.
// Ports: none (package).
package pipe_pkg;

  localparam int WB_W        = 2;
  localparam int WB_REGWRITE = 0;
  localparam int WB_MEMTOREG = 1;
  localparam int REG_ZERO    = 0;

  typedef logic [WB_W-1:0] wbField_t;

  function automatic logic wbRegWrite(input wbField_t f);
    return f[WB_REGWRITE];
  endfunction

  function automatic logic wbMemToReg(input wbField_t f);
    return f[WB_MEMTOREG];
  endfunction

endpackage

// File: rtl/mem_wb_writeback_if.sv
// rtl/mem_wb_writeback_if.sv - MEM/WB stage bus bundle
//
// Purpose: groups the MEM-stage inputs, pipeline controls and the
// register-file write port / retire count of the writeback stage.
// Modports:
//   master - drives mem_*, wb_stall, wb_flush; observes write port
//   slave  - the writeback stage itself
// With FORWARD_EN defined, ex_rs/ex_rt and fwd_* are added.
interface mem_wb_writeback_if
  import pipe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
);

  logic              mem_valid;
  wbField_t          mem_wb;
  logic [REG_AW-1:0] mem_rd;
  logic [DATA_W-1:0] mem_alu_result;
  logic [DATA_W-1:0] mem_rdata;
  logic              wb_stall;
  logic              wb_flush;
  logic              reg_we;
  logic [REG_AW-1:0] reg_waddr;
  logic [DATA_W-1:0] reg_wdata;
  logic              wb_valid;
  logic [CNT_W-1:0]  retired;
`ifdef FORWARD_EN
  logic [REG_AW-1:0] ex_rs;
  logic [REG_AW-1:0] ex_rt;
  logic              fwd_rs_hit;
  logic              fwd_rt_hit;
  logic [DATA_W-1:0] fwd_data;
`endif

  modport master (
    output mem_valid, mem_wb, mem_rd, mem_alu_result, mem_rdata,
    output wb_stall, wb_flush,
`ifdef FORWARD_EN
    output ex_rs, ex_rt,
    input  fwd_rs_hit, fwd_rt_hit, fwd_data,
`endif
    input  reg_we, reg_waddr, reg_wdata, wb_valid, retired
  );

  modport slave (
    input  mem_valid, mem_wb, mem_rd, mem_alu_result, mem_rdata,
    input  wb_stall, wb_flush,
`ifdef FORWARD_EN
    input  ex_rs, ex_rt,
    output fwd_rs_hit, fwd_rt_hit, fwd_data,
`endif
    output reg_we, reg_waddr, reg_wdata, wb_valid, retired
  );

endinterface

// File: rtl/wb_retire_counter.sv
// rtl/wb_retire_counter.sv - retired-instruction up-counter
//
// Purpose: CNT_W-wide counter, wraps silently at 2^CNT_W-1.
// Ports: clk, rst (async active-high), en (count this edge), count.
module wb_retire_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (en) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/mem_wb_writeback.sv
// rtl/mem_wb_writeback.sv - MEM/WB pipeline register and writeback stage
//
// Purpose: registers the MEM-stage result, drives the register-file write
// port combinationally from those registers, and counts retirements.
// Ports:
//   clk, rst - pipeline clock, asynchronous active-high reset
//   bus      - mem_wb_writeback_if.slave (MEM inputs, stall/flush,
//              reg_we/reg_waddr/reg_wdata, wb_valid, retired)
// Optional macro FORWARD_EN: adds WB->EX forwarding hit detection
// (ex_rs/ex_rt in, fwd_rs_hit/fwd_rt_hit/fwd_data out).
module mem_wb_writeback
  import pipe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
) (
  input  logic               clk,
  input  logic               rst,
  mem_wb_writeback_if.slave  bus
);

  logic              validQ;
  wbField_t          wbQ;
  logic [REG_AW-1:0] rdQ;
  logic [DATA_W-1:0] aluQ;
  logic [DATA_W-1:0] rdataQ;
  logic              retireEn;
  logic              regWe;

  // Flush only clears the control bits; data registers simply hold since
  // a bubble never writes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      validQ <= 1'b0;
      wbQ    <= '0;
      rdQ    <= '0;
      aluQ   <= '0;
      rdataQ <= '0;
    end else if (bus.wb_flush) begin
      validQ <= 1'b0;
      wbQ    <= '0;
    end else if (!bus.wb_stall) begin
      validQ <= bus.mem_valid;
      wbQ    <= bus.mem_wb;
      rdQ    <= bus.mem_rd;
      aluQ   <= bus.mem_alu_result;
      rdataQ <= bus.mem_rdata;
    end
  end

  // Bubbles never write whatever wbQ holds, and r0 is never written.
  assign regWe = validQ & wbRegWrite(wbQ) & (rdQ != REG_AW'(REG_ZERO));

  assign bus.reg_we    = regWe;
  assign bus.reg_waddr = rdQ;
  assign bus.reg_wdata = wbMemToReg(wbQ) ? rdataQ : aluQ;
  assign bus.wb_valid  = validQ;

  // The WB occupant leaves when the stage advances; a flush also evicts
  // it as completed, even when a stall is asserted alongside.
  assign retireEn = validQ & (~bus.wb_stall | bus.wb_flush);

  wb_retire_counter #(
    .CNT_W (CNT_W)
  ) u_retire (
    .clk   (clk),
    .rst   (rst),
    .en    (retireEn),
    .count (bus.retired)
  );

`ifdef FORWARD_EN
  assign bus.fwd_rs_hit = regWe & (bus.ex_rs == rdQ);
  assign bus.fwd_rt_hit = regWe & (bus.ex_rt == rdQ);
  assign bus.fwd_data   = bus.reg_wdata;
`endif

endmodule

// File: tb/tb_mem_wb_writeback.sv
// tb/tb_mem_wb_writeback.sv - self-checking bench for mem_wb_writeback
module tb_mem_wb_writeback;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  mem_wb_writeback_if #(.DATA_W(32), .REG_AW(5), .CNT_W(4)) bus ();

  mem_wb_writeback #(.DATA_W(32), .REG_AW(5), .CNT_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic [1:0]  wb;
    logic [4:0]  rd;
    logic [31:0] alu;
    logic [31:0] rdata;
    logic        stall;
    logic        flush;
    logic        eWe;
    logic [4:0]  eAddr;
    logic [31:0] eData;
    logic        eValid;
    logic [3:0]  eRet;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic [1:0] w, input logic [4:0] r,
                       input logic [31:0] a, input logic [31:0] d,
                       input logic s, input logic f);
    bus.mem_valid      = v;
    bus.mem_wb         = w;
    bus.mem_rd         = r;
    bus.mem_alu_result = a;
    bus.mem_rdata      = d;
    bus.wb_stall       = s;
    bus.wb_flush       = f;
  endtask

  function automatic vec_t mk(input logic v, input logic [1:0] w, input logic [4:0] r,
                              input logic [31:0] a, input logic [31:0] d,
                              input logic s, input logic f,
                              input logic eWe, input logic [4:0] eAddr,
                              input logic [31:0] eData, input logic eValid,
                              input logic [3:0] eRet);
    vec_t t;
    t.valid = v; t.wb = w; t.rd = r; t.alu = a; t.rdata = d;
    t.stall = s; t.flush = f; t.eWe = eWe; t.eAddr = eAddr;
    t.eData = eData; t.eValid = eValid; t.eRet = eRet;
    return t;
  endfunction

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    drive(1'b0, 2'b00, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0);
`ifdef FORWARD_EN
    bus.ex_rs = 5'd0;
    bus.ex_rt = 5'd0;
`endif

    //         v  wb     rd     alu           rdata         st  fl  we  addr   data          val ret
    vecs[0]  = mk(1, 2'b01, 5'd8,  32'h0000_1234, 32'h0,        0, 0, 1, 5'd8,  32'h0000_1234, 1, 4'd0);
    vecs[1]  = mk(1, 2'b11, 5'd9,  32'h0000_0100, 32'hDEAD_BEEF, 0, 0, 1, 5'd9,  32'hDEAD_BEEF, 1, 4'd1);
    vecs[2]  = mk(1, 2'b01, 5'd0,  32'h0000_0055, 32'h0,        0, 0, 0, 5'd0,  32'h0000_0055, 1, 4'd2);
    vecs[3]  = mk(0, 2'b01, 5'd5,  32'h0000_0077, 32'h0,        0, 0, 0, 5'd5,  32'h0000_0077, 0, 4'd3);
    vecs[4]  = mk(1, 2'b00, 5'd6,  32'h0000_0088, 32'h0,        0, 0, 0, 5'd6,  32'h0000_0088, 1, 4'd3);
    vecs[5]  = mk(1, 2'b10, 5'd7,  32'h0000_0099, 32'h0000_CAFE, 0, 0, 0, 5'd7,  32'h0000_CAFE, 1, 4'd4);
    vecs[6]  = mk(1, 2'b01, 5'd3,  32'h0000_0033, 32'h0,        0, 0, 1, 5'd3,  32'h0000_0033, 1, 4'd5);
    vecs[7]  = mk(1, 2'b11, 5'd12, 32'h0000_00AA, 32'h0000_00BB, 1, 0, 1, 5'd3,  32'h0000_0033, 1, 4'd5);
    vecs[8]  = mk(1, 2'b11, 5'd12, 32'h0000_00AA, 32'h0000_00BB, 1, 0, 1, 5'd3,  32'h0000_0033, 1, 4'd5);
    vecs[9]  = mk(1, 2'b11, 5'd12, 32'h0000_00AA, 32'h0000_00BB, 1, 0, 1, 5'd3,  32'h0000_0033, 1, 4'd5);
    vecs[10] = mk(1, 2'b11, 5'd12, 32'h0000_00AA, 32'h0000_00BB, 1, 1, 0, 5'd3,  32'h0000_0033, 0, 4'd6);
    vecs[11] = mk(0, 2'b01, 5'd13, 32'h0000_00CC, 32'h0,        0, 0, 0, 5'd13, 32'h0000_00CC, 0, 4'd6);

    @(negedge clk);
    check("rst_we",     32'(bus.reg_we),    32'd0);
    check("rst_waddr",  32'(bus.reg_waddr), 32'd0);
    check("rst_wdata",  bus.reg_wdata,      32'd0);
    check("rst_valid",  32'(bus.wb_valid),  32'd0);
    check("rst_ret",    32'(bus.retired),   32'd0);
`ifdef FORWARD_EN
    check("rst_fwd_rs", 32'(bus.fwd_rs_hit), 32'd0);
    check("rst_fwd_rt", 32'(bus.fwd_rt_hit), 32'd0);
`endif
    rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].valid, vecs[i].wb, vecs[i].rd, vecs[i].alu, vecs[i].rdata,
            vecs[i].stall, vecs[i].flush);
      @(posedge clk);
      @(negedge clk);
      check($sformatf("v%0d_we", i),    32'(bus.reg_we),    32'(vecs[i].eWe));
      check($sformatf("v%0d_waddr", i), 32'(bus.reg_waddr), 32'(vecs[i].eAddr));
      check($sformatf("v%0d_wdata", i), bus.reg_wdata,      vecs[i].eData);
      check($sformatf("v%0d_valid", i), 32'(bus.wb_valid),  32'(vecs[i].eValid));
      check($sformatf("v%0d_ret", i),   32'(bus.retired),   32'(vecs[i].eRet));
    end

    // Asynchronous reset between edges while a write is presented.
    drive(1'b1, 2'b01, 5'd4, 32'h0000_0044, 32'h0, 1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    check("pre_rst_we",  32'(bus.reg_we),  32'd1);
    check("pre_rst_ret", 32'(bus.retired), 32'd6);
    #2;
    rst = 1'b1;
    #1;
    check("arst_we",    32'(bus.reg_we),    32'd0);
    check("arst_valid", 32'(bus.wb_valid),  32'd0);
    check("arst_waddr", 32'(bus.reg_waddr), 32'd0);
    check("arst_ret",   32'(bus.retired),   32'd0);
    @(posedge clk);
    @(negedge clk);
    check("arst_hold_we", 32'(bus.reg_we), 32'd0);
    rst = 1'b0;

    // Counter wrap: first edge fills WB, then 16 retirements wrap to 0.
    drive(1'b1, 2'b01, 5'd1, 32'h0000_0001, 32'h0, 1'b0, 1'b0);
    repeat (16) @(posedge clk);
    @(negedge clk);
    check("wrap_15", 32'(bus.retired), 32'd15);
    @(posedge clk);
    @(negedge clk);
    check("wrap_0", 32'(bus.retired), 32'd0);

`ifdef FORWARD_EN
    drive(1'b1, 2'b01, 5'd7, 32'h0000_0777, 32'h0, 1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    bus.ex_rs = 5'd7;
    bus.ex_rt = 5'd6;
    #1;
    check("fwd_rs_hit", 32'(bus.fwd_rs_hit), 32'd1);
    check("fwd_rt_hit", 32'(bus.fwd_rt_hit), 32'd0);
    check("fwd_data",   bus.fwd_data,        32'h0000_0777);
`endif

    drive(1'b0, 2'b00, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
